// File: rtl/posit_soc_pkg.sv
// ---------------------------------------------------------------------------
// posit_soc_pkg : shared widths and sequencer state encoding
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package posit_soc_pkg;

  localparam int DEF_ADDR_W = 12;
  localparam int DEF_DATA_W = 17;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD   = 3'd1,
    S_ARM    = 3'd2,
    S_WAIT   = 3'd3,
    S_RD_REQ = 3'd4,
    S_RD_CAP = 3'd5,
    S_OUT    = 3'd6
  } seq_state_t;

endpackage

`default_nettype wire

// File: rtl/posit_result_reader.sv
// ---------------------------------------------------------------------------
// posit_result_reader : result memory read, capture and output stream stage
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module posit_result_reader
  import posit_soc_pkg::*;
#(
  parameter int                ADDR_W   = DEF_ADDR_W,
  parameter int                DATA_W   = DEF_DATA_W,
  parameter logic [ADDR_W-1:0] RES_BASE = 12'h010
) (
  input  logic              clock,
  input  logic              reset_n,
  input  seq_state_t        state,
  input  logic [ADDR_W-1:0] last_idx,
  output seq_state_t        rd_next,
  output logic [ADDR_W-1:0] res_address,
  input  logic [DATA_W-1:0] res_readdata,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data
);

  logic [ADDR_W-1:0] idx;
  logic [DATA_W-1:0] data_q;
  logic              in_read;
  logic              out_fire;
  logic              more;

  assign in_read  = state inside {S_RD_REQ, S_RD_CAP, S_OUT};
  assign out_fire = (state == S_OUT) && out_ready;
  // idx counts up from zero, so "not yet last" is the same as idx < N/2-1
  assign more     = (idx != last_idx);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      idx    <= '0;
      data_q <= '0;
    end else begin
      if (!in_read) begin
        idx <= '0;
      end else if (out_fire && more) begin
        idx <= idx + ADDR_W'(1);
      end
      if (state == S_RD_CAP) begin
        data_q <= res_readdata;
      end
    end
  end

  always_comb begin
    rd_next = state;
    case (state)
      S_RD_REQ: rd_next = S_RD_CAP;
      S_RD_CAP: rd_next = S_OUT;
      S_OUT:    if (out_ready) rd_next = more ? S_RD_REQ : S_IDLE;
      default:  rd_next = state;
    endcase
  end

  assign res_address = (state == S_RD_REQ) ? (RES_BASE + idx) : '0;
  assign out_valid   = (state == S_OUT);
  assign out_data    = data_q;

endmodule

`default_nettype wire

// File: rtl/posit_job_sequencer.sv
// ---------------------------------------------------------------------------
// posit_job_sequencer : loads operands, runs the adder wrapper, streams results
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module posit_job_sequencer
  import posit_soc_pkg::*;
#(
  parameter int                ADDR_W   = DEF_ADDR_W,
  parameter int                DATA_W   = DEF_DATA_W,
  parameter logic [ADDR_W-1:0] OP_BASE  = 12'h000,
  parameter logic [ADDR_W-1:0] RES_BASE = 12'h010
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              io_cmd_valid,
  output logic              io_cmd_ready,
  input  logic [ADDR_W-1:0] io_cmd_count,
  output logic              io_cmd_error,
  input  logic              io_in_valid,
  output logic              io_in_ready,
  input  logic [DATA_W-1:0] io_in_data,
  output logic [ADDR_W-1:0] io_op_address,
  output logic              io_op_write,
  output logic [DATA_W-1:0] io_op_writedata,
  output logic              io_accel_start,
  input  logic              io_accel_completed,
  output logic [ADDR_W-1:0] io_res_address,
  input  logic [DATA_W-1:0] io_res_readdata,
  output logic              io_out_valid,
  input  logic              io_out_ready,
  output logic [DATA_W-1:0] io_out_data,
  output logic              io_busy
);

  seq_state_t        state, state_nx, rd_next;
  logic [ADDR_W-1:0] n_q, k_q, last_idx;
  logic              seen_low, err_q;
  logic              cmd_fire, cmd_ok, in_fire, done;

  assign cmd_fire = (state == S_IDLE) && io_cmd_valid;
  assign cmd_ok   = (io_cmd_count != '0) && !io_cmd_count[0];
  assign in_fire  = (state == S_LOAD) && io_in_valid;
  // a completed level that was already high when start rose is stale
  assign done     = (state == S_WAIT) && seen_low && io_accel_completed;
  assign last_idx = (n_q >> 1) - ADDR_W'(1);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state    <= S_IDLE;
      n_q      <= '0;
      k_q      <= '0;
      seen_low <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state <= state_nx;
      err_q <= cmd_fire && !cmd_ok;
      if (cmd_fire && cmd_ok) begin
        n_q <= io_cmd_count;
        k_q <= '0;
      end else if (in_fire) begin
        k_q <= k_q + ADDR_W'(1);
      end
      if (state == S_ARM || state == S_WAIT) begin
        if (!io_accel_completed) seen_low <= 1'b1;
      end else begin
        seen_low <= 1'b0;
      end
    end
  end

  always_comb begin
    state_nx        = state;
    io_cmd_ready    = 1'b0;
    io_in_ready     = 1'b0;
    io_op_write     = 1'b0;
    io_op_address   = '0;
    io_op_writedata = '0;
    io_accel_start  = 1'b0;
    case (state)
      S_IDLE: begin
        io_cmd_ready = 1'b1;
        if (cmd_fire && cmd_ok) state_nx = S_LOAD;
      end
      S_LOAD: begin
        io_in_ready = 1'b1;
        if (in_fire) begin
          io_op_write     = 1'b1;
          io_op_address   = OP_BASE + k_q;
          io_op_writedata = io_in_data;
          if (k_q == n_q - ADDR_W'(1)) state_nx = S_ARM;
        end
      end
      S_ARM: begin
        io_accel_start = 1'b1;
        state_nx       = S_WAIT;
      end
      S_WAIT: begin
        io_accel_start = 1'b1;
        if (done) state_nx = S_RD_REQ;
      end
      default: state_nx = rd_next;
    endcase
  end

  assign io_cmd_error = err_q;
  assign io_busy      = (state != S_IDLE);

  posit_result_reader #(
    .ADDR_W   (ADDR_W),
    .DATA_W   (DATA_W),
    .RES_BASE (RES_BASE)
  ) u_reader (
    .clock        (clock),
    .reset_n      (reset_n),
    .state        (state),
    .last_idx     (last_idx),
    .rd_next      (rd_next),
    .res_address  (io_res_address),
    .res_readdata (io_res_readdata),
    .out_valid    (io_out_valid),
    .out_ready    (io_out_ready),
    .out_data     (io_out_data)
  );

endmodule

`default_nettype wire

// File: doc/posit_job_sequencer.md
POSIT_JOB_SEQUENCER -- requirements
Module: posit_job_sequencer

Interface
REQ-001 SHALL have parameter ADDR_W, default 12, memory address width.
REQ-002 SHALL have parameter DATA_W, default 17, memory word width.
REQ-003 SHALL have parameter OP_BASE, default 12'h000, operand memory base address.
REQ-004 SHALL have parameter RES_BASE, default 12'h010, result memory base address.
REQ-005 SHALL have port clock  in  1  the single clock; all logic is on its rising edge.
REQ-006 SHALL have port reset_n  in  1  reset, asynchronous and active-low.
REQ-007 SHALL have ports io_cmd_valid in 1, io_cmd_ready out 1, io_cmd_count in ADDR_W: job command giving operand word count N.
REQ-008 SHALL have port io_cmd_error  out  1  one-cycle pulse when a command is rejected.
REQ-009 SHALL have ports io_in_valid in 1, io_in_ready out 1, io_in_data in DATA_W: operand word stream.
REQ-010 SHALL have ports io_op_address out ADDR_W, io_op_write out 1, io_op_writedata out DATA_W: operand memory write port.
REQ-011 SHALL have ports io_accel_start out 1, io_accel_completed in 1: adder-wrapper handshake.
REQ-012 SHALL have ports io_res_address out ADDR_W, io_res_readdata in DATA_W: result memory read port with 1-cycle read latency.
REQ-013 SHALL have ports io_out_valid out 1, io_out_ready in 1, io_out_data out DATA_W: result stream.
REQ-014 SHALL have port io_busy  out  1  high in every state except IDLE.

Function
REQ-015 SHALL implement states IDLE, LOAD, ARM, WAIT, RD_REQ, RD_CAP, OUT.
REQ-016 In IDLE, io_cmd_ready SHALL be 1; a handshake with N even and N>=2 SHALL latch N and go to LOAD.
REQ-017 A handshake with N=0 or N odd SHALL pulse io_cmd_error for exactly one cycle and remain in IDLE.
REQ-018 In LOAD, io_in_ready SHALL be 1; each in handshake SHALL drive io_op_write=1, io_op_writedata=io_in_data, and io_op_address=OP_BASE+k (k = 0..N-1) in that same cycle.
REQ-019 io_op_write SHALL be 0 whenever no in handshake occurs; io_in_ready SHALL be 0 outside LOAD.
REQ-020 After the N-th word is written, the next cycle SHALL be ARM.
REQ-021 In ARM, io_accel_start SHALL be asserted and held through WAIT until job completion is detected.
REQ-022 Completion SHALL be qualified: io_accel_completed must be observed low at least once after start assertion, then high; a completed level already high at ARM entry SHALL be ignored.
REQ-023 On qualified completion, io_accel_start SHALL deassert in the next cycle and the FSM SHALL go to RD_REQ with result index j=0.
REQ-024 RD_REQ SHALL drive io_res_address=RES_BASE+j; RD_CAP SHALL capture io_res_readdata into the output register; OUT SHALL hold io_out_valid=1 with stable io_out_data until io_out_ready.
REQ-025 On out handshake, if j<N/2-1 the FSM SHALL increment j and go to RD_REQ; otherwise it SHALL go to IDLE.
REQ-026 Minimum result throughput SHALL be one word per 3 cycles; io_out_ready held low SHALL stall indefinitely without data loss.
REQ-027 All address arithmetic SHALL be modulo 2^ADDR_W (base+offset wraps).
REQ-028 Commands arriving outside IDLE SHALL NOT be accepted (io_cmd_ready=0).

Reset
REQ-029 reset_n low SHALL asynchronously force IDLE, clear k, j, N, and the completion qualifier, and drive all outputs to 0 except io_cmd_ready=1.
REQ-030 Reset mid-job SHALL abandon the job; no partial write, start, or out beat SHALL follow reset release.

Structure
REQ-031 The state enumeration and ADDR_W/DATA_W defaults SHALL reside in a shared package posit_soc_pkg.
REQ-032 The result-read/output path SHALL be one sub-module, posit_result_reader (RD_REQ/RD_CAP/OUT plus output register).

Verification
REQ-033 cmd N=4, words 0x00040,0x00048,0x00050,0x00058 -> writes at addresses 0x000..0x003 in order, then start=1.
REQ-034 completed already high at ARM entry, later low then high after 5 cycles -> start held until the qualified rise, drops the next cycle.
REQ-035 results 0x00060,0x00070 at 0x010,0x011 with out_ready=1 -> out_data 0x00060 then 0x00070, then busy=0.
REQ-036 cmd N=3, then N=0 -> cmd_error one-cycle pulse each time, no memory write, busy stays 0.
REQ-037 out_ready low for 10 cycles during OUT -> out_valid held, out_data stable, no extra res_address advance.
REQ-038 reset_n low for 1 cycle during LOAD after 2 of 4 words -> IDLE, outputs 0, cmd_ready=1; new N=2 job completes normally.
